// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit with req/ack data bus, byte-lane steering and load extension.
// Optional misaligned-access rejection is compiled in with `define LSU_ALIGN_CHECK_EN.
module mem_stage_lsu #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreqM,
  input  logic        memwriteM,
  input  logic [1:0]  sizeM,
  input  logic        unsignedM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        buserrM,
  output logic        misalignM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_next;
  logic [7:0]  cnt;
  logic [8:0]  cnt_inc;
  logic [1:0]  size_p1;
  logic [1:0]  off_p1;
  logic        unsigned_p1;
  logic        err_p1;
  logic        reject;
  logic        issue;
  logic        timeout;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = off[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   lane_wdata = {4{wdata[7:0]}};
      2'b01:   lane_wdata = {2{wdata[15:0]}};
      default: lane_wdata = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] rdata, input logic [1:0] size,
                                           input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   load_ext = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_ext = rdata;
    endcase
  endfunction

`ifdef LSU_ALIGN_CHECK_EN
  logic misaligned;
  always_comb begin
    case (sizeM)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = aluoutM[0];
      default: misaligned = |aluoutM[1:0];
    endcase
  end
  assign reject = (state == IDLE) & memreqM & misaligned;
`else
  assign reject = 1'b0;
`endif

  assign misalignM = reject;
  assign issue     = (state == IDLE) & memreqM & ~reject;
  assign stallM    = memreqM & (state != DONE) & ~reject;
  assign bus_req   = (state == BUSY);
  assign buserrM   = (state == DONE) & err_p1;
  assign cnt_inc   = {1'b0, cnt} + 9'd1;
  assign timeout   = ~bus_ack & (cnt_inc == 9'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue) state_next = BUSY;
      BUSY:    if (bus_ack || timeout) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Access fields latched at issue; they only steer load extension so need no reset.
  always_ff @(posedge clk) begin
    if (issue) begin
      size_p1     <= sizeM;
      off_p1      <= aluoutM[1:0];
      unsigned_p1 <= unsignedM;
    end
  end

  // Bus registers live only across BUSY; readdataM updates on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 8'd0;
      err_p1    <= 1'b0;
      readdataM <= 32'h0;
      bus_we    <= 1'b0;
      bus_be    <= 4'h0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            cnt       <= 8'd0;
            err_p1    <= 1'b0;
            bus_we    <= memwriteM;
            bus_be    <= lane_be(sizeM, aluoutM[1:0]);
            bus_addr  <= {aluoutM[31:2], 2'b00};
            bus_wdata <= lane_wdata(sizeM, writedataM);
          end
        end
        BUSY: begin
          if (bus_ack || timeout) begin
            bus_we    <= 1'b0;
            bus_be    <= 4'h0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            if (timeout) begin
              err_p1    <= 1'b1;
              readdataM <= 32'h0;
            end else if (!bus_we) begin
              readdataM <= load_ext(bus_rdata, size_p1, off_p1, unsigned_p1);
            end
          end else begin
            cnt <= cnt_inc[7:0];
          end
        end
        default: begin
          err_p1 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (MAX_WAIT = 4 so the timeout path is reachable quickly).
module tb_mem_stage_lsu;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memreqM, memwriteM, unsignedM;
  logic [1:0]  sizeM;
  logic [31:0] aluoutM, writedataM;
  logic [31:0] readdataM;
  logic        stallM, buserrM, misalignM;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int tests_run = 0;
  int tests_failed = 0;

  int          obs_stalls, obs_req, obs_first_req, obs_err;
  logic        obs_mis, obs_we, obs_done, obs_bus_clear;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata, obs_rd;

  always #5 clk = ~clk;

  mem_stage_lsu #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .memreqM(memreqM), .memwriteM(memwriteM), .sizeM(sizeM),
    .unsignedM(unsignedM), .aluoutM(aluoutM), .writedataM(writedataM), .readdataM(readdataM),
    .stallM(stallM), .buserrM(buserrM), .misalignM(misalignM), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  // Runs one access starting at T0 (called just after a rising edge); ack is high in cycle ack_at.
  task automatic run_access(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rword, input int ack_at);
    int cyc;
    memreqM = 1'b1; memwriteM = we; sizeM = sz; unsignedM = uns;
    aluoutM = addr; writedataM = wd; bus_rdata = rword;
    obs_stalls = 0; obs_req = 0; obs_first_req = -1; obs_err = 0;
    obs_mis = 1'b0; obs_done = 1'b0; obs_bus_clear = 1'b0;
    obs_we = 1'b0; obs_be = 4'h0; obs_addr = 32'h0; obs_wdata = 32'h0; obs_rd = 32'h0;
    cyc = 0;
    while (cyc < 40 && !obs_done) begin
      bus_ack = (cyc == ack_at);
      @(negedge clk);
      if (stallM) obs_stalls++;
      if (buserrM) obs_err++;
      if (misalignM) obs_mis = 1'b1;
      if (bus_req) begin
        obs_req++;
        if (obs_first_req < 0) begin
          obs_first_req = cyc;
          obs_we = bus_we; obs_be = bus_be; obs_addr = bus_addr; obs_wdata = bus_wdata;
        end
      end
      if (!stallM) begin
        obs_done = 1'b1;
        obs_rd = readdataM;
        obs_bus_clear = !bus_req && !bus_we && bus_be == 4'h0 && bus_addr == 32'h0 && bus_wdata == 32'h0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    memreqM = 1'b0; bus_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; memreqM = 1'b0; memwriteM = 1'b0; sizeM = 2'b00; unsignedM = 1'b0;
    aluoutM = 32'h0; writedataM = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus_req, bus_we, bus_be, stallM, buserrM, misalignM} !== 9'h0 || bus_addr !== 32'h0 ||
        bus_wdata !== 32'h0 || readdataM !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_state: req=%b we=%b be=%h addr=%h wdata=%h rd=%h stall=%b err=%b, required all 0",
               bus_req, bus_we, bus_be, bus_addr, bus_wdata, readdataM, stallM, buserrM);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_word;
    run_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    tests_run++;
    if (obs_be !== 4'b1111 || obs_addr !== 32'h100 || obs_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL lw_bus: be=%b addr=%h we=%b, required 1111 00000100 0", obs_be, obs_addr, obs_we);
    end
    tests_run++;
    if (obs_stalls !== 2 || obs_first_req !== 1) begin
      tests_failed++;
      $display("FAIL lw_stall: stalls=%0d first_req=%0d, required 2 and 1", obs_stalls, obs_first_req);
    end
    tests_run++;
    if (obs_rd !== 32'hDEADBEEF || !obs_done) begin
      tests_failed++;
      $display("FAIL lw_data: rd=%h done=%b, required deadbeef 1", obs_rd, obs_done);
    end
    tests_run++;
    if (!obs_bus_clear || obs_err !== 0) begin
      tests_failed++;
      $display("FAIL lw_done_bus: clear=%b err=%0d, required 1 and 0", obs_bus_clear, obs_err);
    end
  endtask

  task automatic test_back_to_back;
    run_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80123456, 3);
    tests_run++;
    if (obs_rd !== 32'hFFFFFF80 || obs_stalls !== 4 || obs_be !== 4'b1000) begin
      tests_failed++;
      $display("FAIL lb_signed: rd=%h stalls=%0d be=%b, required ffffff80 4 1000", obs_rd, obs_stalls, obs_be);
    end
    run_access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80123456, 3);
    tests_run++;
    if (obs_rd !== 32'h00000080 || obs_stalls !== 4) begin
      tests_failed++;
      $display("FAIL lbu_unsigned: rd=%h stalls=%0d, required 00000080 4", obs_rd, obs_stalls);
    end
    tests_run++;
    if (obs_first_req !== 1) begin
      tests_failed++;
      $display("FAIL b2b_gap: second bus_req first seen cycle %0d, required 1", obs_first_req);
    end
  endtask

  task automatic test_store_half;
    run_access(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, 32'h11111111, 1);
    tests_run++;
    if (obs_we !== 1'b1 || obs_be !== 4'b1100 || obs_wdata !== 32'hABCDABCD || obs_addr !== 32'h20) begin
      tests_failed++;
      $display("FAIL sh_bus: we=%b be=%b wdata=%h addr=%h, required 1 1100 abcdabcd 00000020",
               obs_we, obs_be, obs_wdata, obs_addr);
    end
    tests_run++;
    if (obs_rd !== 32'h00000080) begin
      tests_failed++;
      $display("FAIL sh_keeps_rd: rd=%h, required 00000080", obs_rd);
    end
  endtask

  task automatic test_lanes;
    run_access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80123456, 2);
    tests_run++;
    if (obs_rd !== 32'hFFFF8012 || obs_be !== 4'b1100 || obs_stalls !== 3) begin
      tests_failed++;
      $display("FAIL lh_upper: rd=%h be=%b stalls=%0d, required ffff8012 1100 3", obs_rd, obs_be, obs_stalls);
    end
    run_access(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h80129456, 1);
    tests_run++;
    if (obs_rd !== 32'h00009456 || obs_be !== 4'b0011) begin
      tests_failed++;
      $display("FAIL lhu_lower: rd=%h be=%b, required 00009456 0011", obs_rd, obs_be);
    end
    run_access(1'b1, 2'b00, 1'b0, 32'h101, 32'h123456A5, 32'h0, 1);
    tests_run++;
    if (obs_be !== 4'b0010 || obs_wdata !== 32'hA5A5A5A5 || obs_addr !== 32'h100 || obs_we !== 1'b1) begin
      tests_failed++;
      $display("FAIL sb_bus: be=%b wdata=%h addr=%h we=%b, required 0010 a5a5a5a5 00000100 1",
               obs_be, obs_wdata, obs_addr, obs_we);
    end
  endtask

  task automatic test_timeout;
    run_access(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h55555555, -1);
    tests_run++;
    if (obs_req !== MAX_WAIT || obs_stalls !== MAX_WAIT + 1) begin
      tests_failed++;
      $display("FAIL timeout_len: req_cycles=%0d stalls=%0d, required %0d %0d", obs_req, obs_stalls,
               MAX_WAIT, MAX_WAIT + 1);
    end
    tests_run++;
    if (obs_err !== 1 || obs_rd !== 32'h0 || !obs_done) begin
      tests_failed++;
      $display("FAIL timeout_err: err_pulses=%0d rd=%h done=%b, required 1 00000000 1", obs_err, obs_rd, obs_done);
    end
    @(negedge clk);
    tests_run++;
    if (bus_req !== 1'b0 || buserrM !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_idle: req=%b err=%b, required 0 0", bus_req, buserrM);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_busy;
    memreqM = 1'b1; memwriteM = 1'b1; sizeM = 2'b10; unsignedM = 1'b0;
    aluoutM = 32'h200; writedataM = 32'h77777777; bus_ack = 1'b0; bus_rdata = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (bus_req !== 1'b1 || bus_be !== 4'hF) begin
      tests_failed++;
      $display("FAIL rst_busy_pre: req=%b be=%b, required 1 1111", bus_req, bus_be);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; memreqM = 1'b0; memwriteM = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    tests_run++;
    if ({bus_req, bus_we, bus_be} !== 6'h0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 ||
        readdataM !== 32'h0 || stallM !== 1'b0 || buserrM !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_busy_bus: req=%b we=%b be=%b addr=%h wdata=%h rd=%h err=%b, required all 0",
               bus_req, bus_we, bus_be, bus_addr, bus_wdata, readdataM, buserrM);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    tests_run++;
    if (readdataM !== 32'h0 || bus_req !== 1'b0 || buserrM !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_late_ack: rd=%h req=%b err=%b, required 00000000 0 0", readdataM, bus_req, buserrM);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_misalign;
`ifdef LSU_ALIGN_CHECK_EN
    memreqM = 1'b1; memwriteM = 1'b0; sizeM = 2'b10; unsignedM = 1'b0; aluoutM = 32'h102;
    bus_rdata = 32'h01020304;
    @(negedge clk);
    tests_run++;
    if (misalignM !== 1'b1 || stallM !== 1'b0 || bus_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL misalign_reject: mis=%b stall=%b req=%b, required 1 0 0", misalignM, stallM, bus_req);
    end
    @(posedge clk); #1;
    memreqM = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus_req !== 1'b0 || readdataM !== 32'h0) begin
      tests_failed++;
      $display("FAIL misalign_nobus: req=%b rd=%h, required 0 00000000", bus_req, readdataM);
    end
    @(posedge clk); #1;
`else
    run_access(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h01020304, 1);
    tests_run++;
    if (obs_addr !== 32'h100 || obs_be !== 4'b1111 || obs_mis !== 1'b0) begin
      tests_failed++;
      $display("FAIL misalign_issue: addr=%h be=%b mis=%b, required 00000100 1111 0", obs_addr, obs_be, obs_mis);
    end
    tests_run++;
    if (obs_rd !== 32'h01020304) begin
      tests_failed++;
      $display("FAIL misalign_data: rd=%h, required 01020304", obs_rd);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_load_word;
    test_back_to_back;
    test_store_half;
    test_lanes;
    test_timeout;
    test_reset_busy;
    test_misalign;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
